serial_add_sequencer: RTL and testbench



---
 rtl/serial_add_sequencer.sv | 115 +++++++++++
 tb/tb_serial_add_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract unit: one full_adder cell processes one bit per clock,
// LSB first, with a start/busy/done handshake and held result flags.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_sum, fa_cout;
    logic             last_bit;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign res_nxt  = {fa_sum, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result and flags are written only on the last bit, so they never show partial sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            S      <= '0;
            Cout   <= 1'b0;
            V      <= 1'b0;
            Z      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    a_sh  <= A;
                    b_sh  <= sub ? ~B : B;
                    carry <= sub;
                    cnt   <= '0;
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_cout;
                    res_sh <= res_nxt;
                    if (last_bit) begin
                        S    <= res_nxt;
                        Cout <= fa_cout;
                        V    <= carry ^ fa_cout;
                        Z    <= ~|res_nxt;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer: an arithmetic reference model checked
// every cycle, plus literal expectations for each directed operation.

module tb_serial_add_sequencer;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, Cout, V, Z;
    logic [W-1:0] S;

    int n_cmp = 0;
    int n_bad = 0;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
        .busy(busy), .done(done), .S(S), .Cout(Cout), .V(V), .Z(Z)
    );

    always #5 clk = ~clk;

    // Reference model: cycles remaining in the current operation, result published at the end.
    int           m_left = 0;
    logic [W-1:0] m_S = '0, p_S = '0;
    logic         m_C = 1'b0, m_V = 1'b0, m_Z = 1'b0;
    logic         p_C = 1'b0, p_V = 1'b0, p_Z = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_S = '0; m_C = 1'b0; m_V = 1'b0; m_Z = 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                logic [W:0]   full;
                logic [W-1:0] bb;
                bb   = sub ? ~B : B;
                full = {1'b0, A} + {1'b0, bb} + {{W{1'b0}}, sub};
                p_S  = full[W-1:0];
                p_C  = full[W];
                p_Z  = (p_S == '0);
                if (sub) p_V = (A[W-1] != B[W-1]) && (p_S[W-1] != A[W-1]);
                else     p_V = (A[W-1] == B[W-1]) && (p_S[W-1] != A[W-1]);
                m_left = W + 1;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 1) begin
                m_S = p_S; m_C = p_C; m_V = p_V; m_Z = p_Z;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Advance one clock and compare every output against the model on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check("busy", 64'(busy), 64'(m_left != 0));
        check("done", 64'(done), 64'(m_left == 1));
        check("S",    64'(S),    64'(m_S));
        check("flags", 64'({Cout, V, Z}), 64'({m_C, m_V, m_Z}));
    endtask

    task automatic wait_done(output int busy_cycles);
        bit seen = 0;
        busy_cycles = 0;
        for (int i = 0; i < int'(W) + 5; i++) begin
            step();
            if (busy) busy_cycles++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("done_timeout", 64'(seen), 64'(1));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] e_s, input logic e_c, input logic e_v,
                          input logic e_z);
        int bc;
        A = a; B = b; sub = s; start = 1'b1;
        step();
        if (busy) bc = 1; else bc = 0;
        start = 1'b0;
        begin
            int rest;
            wait_done(rest);
            bc += rest;
        end
        check("busy_cycles", 64'(bc), 64'(W + 1));
        check("lit_S", 64'(S), 64'(e_s));
        check("lit_flags", 64'({Cout, V, Z}), 64'({e_c, e_v, e_z}));
        check("model_S", 64'(m_S), 64'(e_s));
        step();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check("rst_outs", 64'({busy, done, S, Cout, V, Z}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op(32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_op(32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op(32'd5, 32'd5, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        run_op(32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        // back-to-back: run_op returns on the first IDLE cycle
        run_op(32'd1000, 32'd1, 1'b1, 32'd999, 1'b1, 1'b0, 1'b0);

        // start during RUN is ignored; S holds the previous result until the last bit
        A = 32'd10; B = 32'd20; sub = 1'b0; start = 1'b1;
        step();
        A = 32'd1; B = 32'd1;
        for (int i = 0; i < 10; i++) begin
            sub = ~sub; A = A ^ 32'h5;
            step();
            check("hold_S", 64'(S), 64'(32'd999));
        end
        start = 1'b0;
        begin
            int bc;
            wait_done(bc);
        end
        check("ign_S", 64'(S), 64'(32'd30));
        for (int i = 0; i < int'(W) + 3; i++) begin
            step();
            check("no_2nd_done", 64'(done), 64'(0));
        end

        // reset mid-RUN, between clock edges
        A = 32'h0000_AAAA; B = 32'h0000_5555; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        #1 check("midrun_rst", 64'({busy, done, S, Cout, V, Z}), 64'(0));
        step();
        step();
        check("rst_no_done", 64'(done), 64'(0));
        rst_n = 1'b1;
        step();
        run_op(32'd100, 32'd23, 1'b0, 32'd123, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
